ripple_carry_adder_serial: RTL and testbench
============================================

Name: ripple_carry_adder_serial

Overview:
- Multi-cycle, parametrised-width ripple adder/subtractor. Processes operands CHUNK bits per clock, LSB first, through one CHUNK-bit ripple stage and a registered carry.
- Trades latency for area compared with the flat 8-bit dataflow adder.
- Sits between operand producers and consumers behind valid/ready handshakes on both sides.
- Adds a subtract mode and a signed-overflow flag.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 2, bits added per clock cycle. 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands A, B, Cin and sub are valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in when sub=0; borrow-in when sub=1.
- sub  input  1  0: S=A+B+Cin; 1: S=A-B-Cin.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- S  output  WIDTH  result, modulo 2^WIDTH.
- Cout  output  1  carry-out of the final chunk. In sub mode, 1 means no borrow.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset: rst_n sampled low at a rising edge. State <= IDLE; S, Cout, ovf, out_valid <= 0; internal chunk counter and carry <= 0. in_ready is 0 while reset is applied.
- Reset dominates everything. Reset during RUN or DONE aborts the operation; the result is discarded and never presented.
- NCHUNK = WIDTH/CHUNK.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> RUN on in_valid && in_ready at the edge. At that edge:
  - latch a_reg=A;
  - latch b_reg = sub ? ~B : B;
  - carry = sub ? ~Cin : Cin;
  - chunk counter k=0.
- RUN, each edge:
  - {c, s} = a_reg[k*CHUNK +: CHUNK] + b_reg[k*CHUNK +: CHUNK] + carry;
  - write S[k*CHUNK +: CHUNK] = s; carry <= c; k <= k+1.
  - On the chunk with k = NCHUNK-1: Cout <= c; ovf <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1; go to DONE.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge. Example: WIDTH=8, CHUNK=2 gives 4 cycles.
- DONE: S, Cout and ovf are held stable while out_valid=1 && out_ready=0 (backpressure of any length). Transfer on out_valid && out_ready, then go to IDLE. in_ready is high the following cycle.
- No overlap: at most one operation in flight. The minimum issue interval is NCHUNK+2 cycles with out_ready tied high.
- Operand inputs are don't-care outside the accepting edge. Changes during RUN have no effect.
- S bits not yet written in RUN are undefined to consumers. Outputs are architecturally valid only when out_valid=1. The implementation clears S at acceptance.
- in_valid while not in IDLE is ignored. The producer must hold it until in_ready.
- CHUNK == WIDTH is legal: NCHUNK=1, single-cycle RUN.

Decomposition:
- Shared package/header rca_pkg:
  - state encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - a helper function computing NCHUNK and counter width (clog2 of NCHUNK, minimum 1).
- One sub-module, rca_chunk: parametrised CHUNK-bit combinational ripple adder built from full adders.
  - Inputs a, b, cin. Outputs s, cout, and c_msb (carry into the top bit, for ovf).
  - Instantiated once, muxed by the chunk counter.
- Elaboration-time check: WIDTH % CHUNK != 0 triggers a $error.

Test Plan (WIDTH=8, CHUNK=2 unless stated):
- A=0x01, B=0x01, Cin=0, sub=0 -> S=0x02, Cout=0, ovf=0. out_valid exactly 4 cycles after acceptance.
- A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1, ovf=0. A=0x7F, B=0x01 -> S=0x80, Cout=0, ovf=1. A=0xFF, B=0xFF, Cin=0 -> S=0xFE, Cout=1, ovf=0.
- sub=1: A=0x05, B=0x03, Cin=0 -> S=0x02, Cout=1. A=0x03, B=0x05, Cin=0 -> S=0xFE, Cout=0. A=0x80, B=0x01 -> S=0x7F, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> S, Cout, ovf stable and in_ready=0. Release -> one transfer, in_ready=1 next cycle. Operand changes during RUN do not alter the result.
- Reset: drive rst_n=0 for one edge mid-RUN (after 2 chunks) -> next cycle state IDLE, out_valid=0, S=0, in_ready=1 after rst_n returns high. The aborted result never appears.
- Parameter sweep: WIDTH=16 with CHUNK in {1, 4, 16}, random operands and modes -> results match a reference model (A±B±Cin); latency equals 16, 4 and 1 respectively.

Source files
------------

// File: rtl/rca_pkg.sv
// rca_pkg: shared definitions for the chunk-serial ripple adder.
//   state_t          - controller state encoding (IDLE/RUN/DONE)
//   calc_nchunk      - number of chunks per operation (WIDTH/CHUNK)
//   calc_cnt_width   - chunk counter width (clog2 of NCHUNK, minimum 1)
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        // Guard the division so an illegal CHUNK still elaborates far enough
        // to reach the parameter checks in the top module.
        return (chunk < 1) ? 1 : width / chunk;
    endfunction

    function automatic int calc_cnt_width(input int width, input int chunk);
        int n;
        n = calc_nchunk(width, chunk);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// rca_chunk: CHUNK-bit combinational ripple-carry adder built from full adders.
// Ports:
//   a, b   [CHUNK-1:0]  operand slices
//   cin                 carry into bit 0
//   s      [CHUNK-1:0]  sum slice
//   cout                carry out of the top bit
//   c_msb               carry into the top bit (used for signed overflow)
module rca_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    // c[i] is the carry into bit i; c[CHUNK] is the carry out of the slice.
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/ripple_carry_adder_serial.sv
// ripple_carry_adder_serial: multi-cycle adder/subtractor that processes the
// operands CHUNK bits per clock, LSB first, through a single rca_chunk and a
// registered carry. One operation in flight; valid/ready on both sides.
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid / in_ready   operand handshake (A, B, Cin, sub)
//   A, B    [WIDTH-1:0]   operands
//   Cin                   carry-in (add) or borrow-in (sub)
//   sub                   0: S = A + B + Cin, 1: S = A - B - Cin
//   out_valid / out_ready result handshake (S, Cout, ovf)
//   S       [WIDTH-1:0]   result modulo 2^WIDTH
//   Cout                  carry out of the top chunk (sub: 1 = no borrow)
//   ovf                   signed two's-complement overflow
module ripple_carry_adder_serial
    import rca_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int KW     = calc_cnt_width(WIDTH, CHUNK);

    if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
        $error("ripple_carry_adder_serial: CHUNK=%0d must be in 1..WIDTH=%0d", CHUNK, WIDTH);
    end
    if (CHUNK >= 1 && (WIDTH % CHUNK) != 0) begin : g_bad_width
        $error("ripple_carry_adder_serial: WIDTH=%0d is not a multiple of CHUNK=%0d", WIDTH, CHUNK);
    end

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [KW-1:0]    k;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] sum_chunk;
    logic             c_out;
    logic             c_msb;
    logic             accept;
    logic             last;

    assign accept  = (state == IDLE) && in_valid && in_ready;
    assign last    = (k == KW'(NCHUNK - 1));
    assign a_chunk = a_reg[int'(k)*CHUNK +: CHUNK];
    assign b_chunk = b_reg[int'(k)*CHUNK +: CHUNK];

    rca_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry),
        .s     (sum_chunk),
        .cout  (c_out),
        .c_msb (c_msb)
    );

    // Controller and result registers.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            S         <= '0;
            Cout      <= 1'b0;
            ovf       <= 1'b0;
            carry     <= 1'b0;
            k         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready comes up one cycle after reset release and
                    // stays up until an operation is accepted.
                    in_ready <= 1'b1;
                    if (accept) begin
                        state    <= RUN;
                        in_ready <= 1'b0;
                        // Subtraction is A + ~B + ~Cin (two's complement with borrow).
                        carry    <= sub ? ~Cin : Cin;
                        k        <= '0;
                        S        <= '0;
                    end
                end
                RUN: begin
                    S[int'(k)*CHUNK +: CHUNK] <= sum_chunk;
                    carry <= c_out;
                    k     <= k + KW'(1);
                    if (last) begin
                        Cout      <= c_out;
                        ovf       <= c_msb ^ c_out;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // S/Cout/ovf are untouched here, so they hold under backpressure.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Operand latches.
    // NOTE: these are pure datapath and only read in RUN after being loaded,
    // so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= A;
            b_reg <= sub ? ~B : B;
        end
    end

endmodule

// File: tb/tb_ripple_carry_adder_serial.sv
// Testbench for ripple_carry_adder_serial: table-driven 8-bit/2-bit vectors,
// backpressure and mid-operation reset sequences, and a 16-bit sweep over
// CHUNK in {1, 4, 16} against a reference model, all through a scoreboard.
`timescale 1ns/1ps
module tb_ripple_carry_adder_serial;

    typedef struct packed {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } vec_t;

    int errors = 0;
    int checks = 0;

    exp_t sb[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 8-bit, CHUNK=2 instance
    logic       in_valid, in_ready, out_valid, out_ready;
    logic       cin, sub, cout, ovf;
    logic [7:0] a, b, s;

    ripple_carry_adder_serial #(
        .WIDTH (8),
        .CHUNK (2)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (s),
        .Cout      (cout),
        .ovf       (ovf)
    );

    // 16-bit sweep instances sharing operands, each with its own handshake
    logic [15:0] a16, b16;
    logic        cin16, sub16;
    logic        v16   [3];
    logic        rdy16 [3];
    logic        ov16  [3];
    logic        cout16[3];
    logic        ovf16 [3];
    logic [15:0] s16   [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int CH = (gi == 0) ? 1 : ((gi == 1) ? 4 : 16);
        ripple_carry_adder_serial #(
            .WIDTH (16),
            .CHUNK (CH)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (v16[gi]),
            .in_ready  (rdy16[gi]),
            .A         (a16),
            .B         (b16),
            .Cin       (cin16),
            .sub       (sub16),
            .out_valid (ov16[gi]),
            .out_ready (1'b1),
            .S         (s16[gi]),
            .Cout      (cout16[gi]),
            .ovf       (ovf16[gi])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic, borrow from sign of the raw difference,
    // overflow from the true signed result leaving the representable range.
    function automatic exp_t model(input int w, input logic [15:0] a_i, input logic [15:0] b_i,
                                   input logic cin_i, input logic sub_i);
        longint mask, half, ua, ub, c, t, sa, sb_v, st;
        exp_t   e;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a_i) & mask;
        ub   = longint'(b_i) & mask;
        c    = longint'(cin_i);
        if (!sub_i) begin
            t      = ua + ub + c;
            e.cout = ((t >> w) & 1) != 0;
        end else begin
            t      = ua - ub - c;
            e.cout = (t >= 0);
        end
        e.s  = 16'(t & mask);
        sa   = (ua >= half) ? ua - (half << 1) : ua;
        sb_v = (ub >= half) ? ub - (half << 1) : ub;
        st   = sub_i ? (sa - sb_v - c) : (sa + sb_v + c);
        e.ovf = (st >= half) || (st < -half);
        return e;
    endfunction

    function automatic int sweep_chunk(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 4 : 16);
    endfunction

    // One 8-bit operation: push expectation, handshake in, scramble operands
    // during RUN, measure latency, compare, optionally hold out_ready low.
    task automatic op8(input vec_t v, input int hold, input string tag);
        int   n;
        int   lat;
        exp_t e;
        sb.push_back('{s: {8'h00, v.s}, cout: v.cout, ovf: v.ovf});
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            check($sformatf("%s in_ready", tag), in_ready, 1);
            in_valid = 1'b0;
            void'(sb.pop_back());
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check($sformatf("%s latency", tag), lat, 4);
        e = sb.pop_front();
        if (!out_valid) return;
        check($sformatf("%s S", tag), s, e.s[7:0]);
        check($sformatf("%s Cout", tag), cout, e.cout);
        check($sformatf("%s ovf", tag), ovf, e.ovf);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check($sformatf("%s hold%0d {ov,rdy,S,C,V}", tag, i),
                  {out_valid, in_ready, s, cout, ovf}, {1'b1, 1'b0, e.s[7:0], e.cout, e.ovf});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check($sformatf("%s after transfer {ov,rdy}", tag), {out_valid, in_ready}, 2'b01);
    endtask

    task automatic op16(input int idx, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic ts);
        int   n;
        int   lat;
        exp_t e;
        sb.push_back(model(16, ta, tb, tc, ts));
        a16 = ta; b16 = tb; cin16 = tc; sub16 = ts;
        v16[idx] = 1'b1;
        n = 0;
        while (!rdy16[idx] && n < 20) begin @(posedge clk); #1; n++; end
        if (!rdy16[idx]) begin
            check($sformatf("w16c%0d in_ready", sweep_chunk(idx)), rdy16[idx], 1);
            v16[idx] = 1'b0;
            void'(sb.pop_back());
            return;
        end
        @(posedge clk); #1;
        v16[idx] = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 0;
        while (!ov16[idx] && lat < 40) begin @(posedge clk); #1; lat++; end
        check($sformatf("w16c%0d latency", sweep_chunk(idx)), lat, 16 / sweep_chunk(idx));
        e = sb.pop_front();
        if (!ov16[idx]) return;
        check($sformatf("w16c%0d %h%s%h+%0d {S,C,V}", sweep_chunk(idx), ta, ts ? "-" : "+", tb, tc),
              {s16[idx], cout16[idx], ovf16[idx]}, {e.s, e.cout, e.ovf});
        @(posedge clk); #1;
        check($sformatf("w16c%0d after transfer {ov,rdy}", sweep_chunk(idx)),
              {ov16[idx], rdy16[idx]}, 2'b01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        vec_t v;
        int   n;
        int   seen;

        vecs[0] = '{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[4] = '{8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[5] = '{8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[7] = '{8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0};
        vecs[8] = '{8'h10, 8'h10, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[9] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
        for (int i = 0; i < 3; i++) v16[i] = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset {rdy,ov,S,C,V}", {in_ready, out_valid, s, cout, ovf}, 12'h000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready after reset release", in_ready, 1);

        // Table-driven vectors
        for (int i = 0; i < 10; i++) op8(vecs[i], 0, $sformatf("vec%0d", i));

        // Backpressure: 10 cycles of out_ready=0 in DONE
        v = '{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1};
        op8(v, 10, "backpressure");

        // Mid-RUN reset after two chunks: result must never appear
        a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        check("abort in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort reset {rdy,ov,S}", {in_ready, out_valid, s}, 10'h000);
        rst_n = 1'b1;
        seen = 0;
        @(posedge clk); #1;
        check("abort in_ready after release", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check("abort result never presented", seen, 0);
        op8(vecs[2], 0, "post-abort");

        // 16-bit sweep across CHUNK = 1, 4, 16
        for (int idx = 0; idx < 3; idx++) begin
            op16(idx, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
            op16(idx, 16'h8000, 16'h0001, 1'b0, 1'b1);
            op16(idx, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
            for (int j = 0; j < 6; j++)
                op16(idx, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        check("scoreboard drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
